// File: rtl/barrel_hart_sched.sv
// Barrel-core hart scheduler: per-hart run state and PC, round-robin issue
// selection over a valid/ready fetch handshake, retire write-back, and a host start port.
module barrel_hart_sched #(
  parameter int unsigned NHARTS = 4,
  parameter int unsigned PCW    = 32,
  localparam int unsigned HW    = $clog2(NHARTS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start_valid,
  input  logic [HW-1:0]     start_hart,
  input  logic [PCW-1:0]    start_pc,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [HW-1:0]     issue_hart,
  output logic [PCW-1:0]    issue_pc,
  input  logic              retire_valid,
  input  logic [HW-1:0]     retire_hart,
  input  logic [PCW-1:0]    retire_next_pc,
  input  logic              retire_halt,
  output logic [NHARTS-1:0] active,
  output logic              all_halted,
  output logic              err,
  output logic [31:0]       retire_count
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StReady    = 2'd1,
    StInflight = 2'd2
  } hart_st_e;

  localparam logic [PCW-1:0] PcAlignMask = ~PCW'(3);

  hart_st_e       st_q [NHARTS];
  hart_st_e       st_d [NHARTS];
  logic [PCW-1:0] pc_q [NHARTS];
  logic [PCW-1:0] pc_d [NHARTS];
  logic [HW-1:0]  rr_ptr_q, rr_ptr_d;
  logic           err_q, err_d;
  logic [31:0]    cnt_q, cnt_d;

  logic           sel_found;
  logic [HW-1:0]  sel_hart;
  logic [HW-1:0]  scan_idx;
  logic           handshake;

  // Round-robin pick: first READY hart scanning upward from rr_ptr, wrapping naturally.
  always_comb begin
    sel_found = 1'b0;
    sel_hart  = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NHARTS; i++) begin
      scan_idx = rr_ptr_q + HW'(i);
      if (!sel_found && (st_q[scan_idx] == StReady)) begin
        sel_found = 1'b1;
        sel_hart  = scan_idx;
      end
    end
  end

  // Offer depends on registered state only; issue_ready never feeds back into it.
  always_comb begin
    issue_valid = sel_found;
    issue_hart  = sel_hart;
    issue_pc    = sel_found ? pc_q[sel_hart] : '0;
    handshake   = sel_found & issue_ready;
  end

  // Next state: issue, retire and start are checked against registered state, so a hart
  // readied this cycle is only eligible next cycle and illegal requests leave it untouched.
  always_comb begin
    st_d     = st_q;
    pc_d     = pc_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    if (handshake) begin
      st_d[sel_hart] = StInflight;
      rr_ptr_d       = sel_hart + HW'(1);
    end
    if (retire_valid) begin
      if (st_q[retire_hart] == StInflight) begin
        st_d[retire_hart] = retire_halt ? StIdle : StReady;
        pc_d[retire_hart] = retire_next_pc & PcAlignMask;
        cnt_d             = cnt_q + 32'd1;
      end else begin
        err_d = 1'b1;
      end
    end
    if (start_valid) begin
      if (st_q[start_hart] == StIdle) begin
        st_d[start_hart] = StReady;
        pc_d[start_hart] = start_pc & PcAlignMask;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NHARTS; i++) begin
        st_q[i] <= StIdle;
        pc_q[i] <= '0;
      end
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      st_q     <= st_d;
      pc_q     <= pc_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Status outputs derived from registered state.
  always_comb begin
    for (int unsigned i = 0; i < NHARTS; i++) begin
      active[i] = (st_q[i] != StIdle);
    end
    all_halted   = ~|active;
    err          = err_q;
    retire_count = cnt_q;
  end

endmodule

// File: tb/tb_barrel_hart_sched.sv
// Self-checking bench for barrel_hart_sched (NHARTS=4, PCW=32): vector table plus
// scoreboarded multi-cycle sequences for rotation, stall, wrap, halt and reset.
module tb_barrel_hart_sched;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start_valid = 1'b0;
  logic [1:0]  start_hart = '0;
  logic [31:0] start_pc = '0;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [1:0]  issue_hart;
  logic [31:0] issue_pc;
  logic        retire_valid = 1'b0;
  logic [1:0]  retire_hart = '0;
  logic [31:0] retire_next_pc = '0;
  logic        retire_halt = 1'b0;
  logic [3:0]  active;
  logic        all_halted;
  logic        err;
  logic [31:0] retire_count;

  barrel_hart_sched #(.NHARTS(4), .PCW(32)) dut (
    .clk(clk), .resetn(resetn),
    .start_valid(start_valid), .start_hart(start_hart), .start_pc(start_pc),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_hart(issue_hart),
    .issue_pc(issue_pc),
    .retire_valid(retire_valid), .retire_hart(retire_hart),
    .retire_next_pc(retire_next_pc), .retire_halt(retire_halt),
    .active(active), .all_halted(all_halted), .err(err), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int sb[$];
  logic [31:0] exp_pc[4];
  logic [1:0]  st_h[3];
  logic [31:0] st_pc[3];

  typedef struct {
    logic sv; logic [1:0] sh; logic [31:0] spc; logic rdy;
    logic rv; logic [1:0] rh; logic [31:0] rpc; logic rhalt;
    logic e_iv; logic [1:0] e_ih; logic [31:0] e_ipc; logic [3:0] e_act;
    logic e_err; logic [31:0] e_cnt;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start_valid = 1'b0; issue_ready = 1'b0; retire_valid = 1'b0; retire_halt = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    for (int i = 0; i < 4; i++) exp_pc[i] = '0;
    sb.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_issue_valid"}, 32'(issue_valid), 32'd0);
    check({tag, "_issue_hart"}, 32'(issue_hart), 32'd0);
    check({tag, "_issue_pc"}, issue_pc, 32'd0);
    check({tag, "_active"}, 32'(active), 32'd0);
    check({tag, "_all_halted"}, 32'(all_halted), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_retire_count"}, retire_count, 32'd0);
  endtask

  // One clock of stimulus; any handshake is checked against the scoreboard head.
  task automatic cyc(input logic sv, input logic [1:0] sh, input logic [31:0] spc,
                     input logic rdy, input logic rv, input logic [1:0] rh,
                     input logic [31:0] rpc, input logic rhalt);
    int eh;
    start_valid = sv; start_hart = sh; start_pc = spc; issue_ready = rdy;
    retire_valid = rv; retire_hart = rh; retire_next_pc = rpc; retire_halt = rhalt;
    if (issue_valid && rdy) begin
      if (sb.size() == 0) begin
        check("unexpected_issue", 32'(issue_hart), 32'hffff_ffff);
      end else begin
        eh = sb.pop_front();
        check("sb_issue_hart", 32'(issue_hart), 32'(eh));
        check("sb_issue_pc", issue_pc, exp_pc[eh]);
      end
    end
    tick();
    if (sv) exp_pc[sh] = spc & ~32'h3;
    if (rv) exp_pc[rh] = rpc & ~32'h3;
    start_valid = 1'b0; issue_ready = 1'b0; retire_valid = 1'b0; retire_halt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    //          sv  sh   spc      rdy rv  rh   rpc      hlt  iv  ih   ipc       act     err cnt
    vecs[0]  = '{1, 2'd2, 32'h103, 0, 0, 2'd0, 32'h0,   0,   1, 2'd2, 32'h100, 4'b0100, 0, 32'd0};
    vecs[1]  = '{0, 2'd0, 32'h0,   0, 0, 2'd0, 32'h0,   0,   1, 2'd2, 32'h100, 4'b0100, 0, 32'd0};
    vecs[2]  = '{0, 2'd0, 32'h0,   1, 0, 2'd0, 32'h0,   0,   0, 2'd0, 32'h0,   4'b0100, 0, 32'd0};
    vecs[3]  = '{0, 2'd0, 32'h0,   0, 1, 2'd2, 32'h105, 0,   1, 2'd2, 32'h104, 4'b0100, 0, 32'd1};
    vecs[4]  = '{1, 2'd1, 32'h20,  0, 0, 2'd0, 32'h0,   0,   1, 2'd1, 32'h20,  4'b0110, 0, 32'd1};
    vecs[5]  = '{0, 2'd0, 32'h0,   1, 0, 2'd0, 32'h0,   0,   1, 2'd2, 32'h104, 4'b0110, 0, 32'd1};
    vecs[6]  = '{1, 2'd1, 32'h999, 0, 1, 2'd1, 32'h44,  0,   1, 2'd2, 32'h104, 4'b0110, 1, 32'd2};
    vecs[7]  = '{0, 2'd0, 32'h0,   0, 1, 2'd3, 32'h10,  0,   1, 2'd2, 32'h104, 4'b0110, 1, 32'd2};
    vecs[8]  = '{0, 2'd0, 32'h0,   1, 0, 2'd0, 32'h0,   0,   1, 2'd1, 32'h44,  4'b0110, 1, 32'd2};
    vecs[9]  = '{0, 2'd0, 32'h0,   1, 1, 2'd2, 32'h200, 1,   0, 2'd0, 32'h0,   4'b0010, 1, 32'd3};
    vecs[10] = '{0, 2'd0, 32'h0,   0, 1, 2'd1, 32'h50,  1,   0, 2'd0, 32'h0,   4'b0000, 1, 32'd4};
    st_h[0] = 2'd0; st_h[1] = 2'd1; st_h[2] = 2'd3;
    st_pc[0] = 32'h0; st_pc[1] = 32'h40; st_pc[2] = 32'h80;

    do_reset();
    check_reset_outputs("reset");

    // Table: start, stall, issue, retire, errors and halts from a clean reset.
    for (int v = 0; v < 11; v++) begin
      start_valid = vecs[v].sv; start_hart = vecs[v].sh; start_pc = vecs[v].spc;
      issue_ready = vecs[v].rdy; retire_valid = vecs[v].rv; retire_hart = vecs[v].rh;
      retire_next_pc = vecs[v].rpc; retire_halt = vecs[v].rhalt;
      tick();
      check($sformatf("v%0d_issue_valid", v), 32'(issue_valid), 32'(vecs[v].e_iv));
      check($sformatf("v%0d_issue_hart", v), 32'(issue_hart), 32'(vecs[v].e_ih));
      check($sformatf("v%0d_issue_pc", v), issue_pc, vecs[v].e_ipc);
      check($sformatf("v%0d_active", v), 32'(active), 32'(vecs[v].e_act));
      check($sformatf("v%0d_all_halted", v), 32'(all_halted), 32'(vecs[v].e_act == 4'b0));
      check($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].e_err));
      check($sformatf("v%0d_retire_count", v), retire_count, vecs[v].e_cnt);
    end

    // Retire of an IDLE hart on its own.
    do_reset();
    check("post_reset_err", 32'(err), 32'd0);
    cyc(0, 2'd0, 32'h0, 0, 1, 2'd2, 32'h40, 0);
    check("idle_retire_err", 32'(err), 32'd1);
    check("idle_retire_count", retire_count, 32'd0);
    check("idle_retire_active", 32'(active), 32'd0);

    // Round-robin over harts 0,1,3 with retire one cycle after each issue.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      sb.push_back(0); sb.push_back(1); sb.push_back(3);
    end
    begin
      int issued = 0;
      int si = 0;
      logic pend = 1'b0;
      logic [1:0] ph = '0;
      for (int c = 0; c < 40 && (issued < 6 || pend); c++) begin
        logic hs;
        logic [1:0] nh;
        hs = issue_valid && (issued < 6);
        nh = issue_hart;
        cyc(si < 3, (si < 3) ? st_h[si] : 2'd0, (si < 3) ? st_pc[si] : 32'h0,
            issued < 6, pend, ph, exp_pc[ph] + 32'd4, 0);
        if (si < 3) si++;
        if (hs) issued++;
        pend = hs;
        ph = nh;
      end
      check("rr_issued", 32'(issued), 32'd6);
    end
    check("rr_retire_count", retire_count, 32'd6);
    check("rr_err", 32'(err), 32'd0);

    // Stall: hart 0 issued, then harts 1 and 3 READY with fetch stalled.
    sb.push_back(0);
    cyc(0, 2'd0, 32'h0, 1, 0, 2'd0, 32'h0, 0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_valid", k), 32'(issue_valid), 32'd1);
      check($sformatf("stall%0d_hart", k), 32'(issue_hart), 32'd1);
      check($sformatf("stall%0d_pc", k), issue_pc, exp_pc[1]);
      cyc(0, 2'd0, 32'h0, 0, 0, 2'd0, 32'h0, 0);
    end
    sb.push_back(1); sb.push_back(3);
    cyc(0, 2'd0, 32'h0, 1, 0, 2'd0, 32'h0, 0);
    cyc(0, 2'd0, 32'h0, 1, 0, 2'd0, 32'h0, 0);

    // Wrap-around: steer rr_ptr to 3 with harts 0 and 3 READY.
    cyc(0, 2'd0, 32'h0, 0, 1, 2'd1, exp_pc[1] + 32'd4, 1);
    cyc(1, 2'd2, 32'h300, 0, 0, 2'd0, 32'h0, 0);
    sb.push_back(2);
    cyc(0, 2'd0, 32'h0, 1, 1, 2'd0, exp_pc[0] + 32'd4, 0);
    cyc(0, 2'd0, 32'h0, 0, 1, 2'd3, exp_pc[3] + 32'd4, 0);
    cyc(0, 2'd0, 32'h0, 0, 1, 2'd2, exp_pc[2] + 32'd4, 1);
    check("wrap_first_hart", 32'(issue_hart), 32'd3);
    check("wrap_first_pc", issue_pc, exp_pc[3]);
    sb.push_back(3); sb.push_back(0);
    cyc(0, 2'd0, 32'h0, 1, 0, 2'd0, 32'h0, 0);
    cyc(0, 2'd0, 32'h0, 1, 0, 2'd0, 32'h0, 0);
    cyc(0, 2'd0, 32'h0, 0, 1, 2'd0, exp_pc[0] + 32'd4, 0);
    cyc(0, 2'd0, 32'h0, 0, 1, 2'd3, exp_pc[3] + 32'd4, 0);
    // rr_ptr=1 now, so hart 3 beats hart 0.
    check("wrap_rr_after", 32'(issue_hart), 32'd3);

    // Halt: retire hart 3 with halt, then hart 0 as the last active hart.
    sb.push_back(3);
    cyc(0, 2'd0, 32'h0, 1, 0, 2'd0, 32'h0, 0);
    cyc(0, 2'd0, 32'h0, 0, 1, 2'd3, 32'h94, 1);
    check("halt_only_h0_active", 32'(active), 32'b0001);
    sb.push_back(0);
    cyc(0, 2'd0, 32'h0, 1, 0, 2'd0, 32'h0, 0);
    cyc(0, 2'd0, 32'h0, 0, 1, 2'd0, 32'h778, 1);
    check("halt_all_halted", 32'(all_halted), 32'd1);
    check("halt_issue_valid", 32'(issue_valid), 32'd0);
    check("halt_active", 32'(active), 32'd0);
    check("halt_pc0", dut.pc_q[0], 32'h778);
    check("halt_retire_count", retire_count, 32'd14);
    check("halt_err", 32'(err), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset mid-run, then a retire for the forgotten in-flight hart.
    cyc(1, 2'd1, 32'h500, 0, 0, 2'd0, 32'h0, 0);
    sb.push_back(1);
    cyc(1, 2'd2, 32'h600, 1, 0, 2'd0, 32'h0, 0);
    check("pre_areset_active", 32'(active), 32'b0110);
    #2 resetn = 1'b0;
    #1;
    check_reset_outputs("areset");
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int i = 0; i < 4; i++) exp_pc[i] = '0;
    cyc(0, 2'd0, 32'h0, 0, 1, 2'd1, 32'h504, 0);
    check("stale_retire_err", 32'(err), 32'd1);
    check("stale_retire_count", retire_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/barrel_hart_sched.md
# barrel_hart_sched

Hardware-thread scheduler for the barrel core. It holds a PC and a run state for each of `NHARTS` harts, and picks which ready hart issues next using rotating (round-robin) priority. It hands that hart's PC to the core's fetch stage over a valid/ready handshake, and takes back the next PC and halt status when the core's writeback retires the instruction. A host-side start port launches idle harts.

## Interface
- `NHARTS`, 4: number of harts; power of two, 2..16.
- `PCW`, 32: PC width.
- `HW`, `$clog2(NHARTS)`: hart index width (derived, not overridable).

- `clk` in 1: the single clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `start_valid` in 1: request to launch hart `start_hart` at `start_pc`.
- `start_hart` in HW: hart to launch.
- `start_pc` in PCW: initial PC; bits [1:0] are forced to 0 on capture.
- `issue_valid` out 1: a ready hart is offered to fetch.
- `issue_ready` in 1: fetch accepts the offer this cycle.
- `issue_hart` out HW: offered hart.
- `issue_pc` out PCW: PC of the offered hart.
- `retire_valid` in 1: writeback retires one instruction.
- `retire_hart` in HW: retiring hart.
- `retire_next_pc` in PCW: next PC; bits [1:0] are forced to 0.
- `retire_halt` in 1: the retiring instruction was a halt.
- `active` out NHARTS: bit h set when hart h is not IDLE.
- `all_halted` out 1: every hart is IDLE.
- `err` out 1: sticky protocol-error flag.
- `retire_count` out 32: total retired instructions; wraps modulo 2^32.

## Operation
- Each hart has a 2-bit state:
  - IDLE: not running.
  - READY: may be offered to fetch.
  - INFLIGHT: issued, waiting for retire.
- Each hart also has a PCW-bit `pc` register.
- Transitions:
  - IDLE -> READY on `start_valid` for that hart; `pc <= start_pc & ~3`.
  - READY -> INFLIGHT on an issue handshake (`issue_valid && issue_ready`) for that hart.
  - INFLIGHT -> READY on `retire_valid` for that hart with `retire_halt=0`; `pc <= retire_next_pc & ~3`.
  - INFLIGHT -> IDLE on `retire_valid` with `retire_halt=1`; `pc <= retire_next_pc & ~3`.
- Selection:
  - `issue_hart` is the first READY hart scanning `rr_ptr`, `rr_ptr+1`, … modulo NHARTS.
  - `issue_valid` = any hart READY.
  - `issue_pc` = `pc[issue_hart]`.
  - All three are combinational from registered state only, with no path from `issue_ready`.
- On an issue handshake, `rr_ptr <= issue_hart + 1`, wrapping modulo NHARTS (HW-bit natural wrap).
- `retire_count` increments by 1 on every accepted retire.
- Protocol errors set `err`, leave the affected state unchanged, and are cleared only by reset:
  - start of a non-IDLE hart;
  - retire of a non-INFLIGHT hart.
- Simultaneous events in one cycle:
  - Issue and retire always target different harts (READY vs INFLIGHT); both take effect.
  - Start and retire of the same hart: retire applies; the start is an error because the hart is INFLIGHT.
  - Start and issue cannot collide (IDLE vs READY).
  - A hart made READY by start or retire becomes eligible in the following cycle, never the same cycle.

## Timing
- Reset values:
  - all harts IDLE;
  - all `pc` = 0;
  - `rr_ptr` = 0;
  - `issue_valid` = 0, `issue_hart` = 0, `issue_pc` = 0;
  - `active` = 0;
  - `all_halted` = 1;
  - `err` = 0;
  - `retire_count` = 0.
- Latency:
  - start at cycle t -> hart can be offered at t+1.
  - retire at t -> the same hart can be offered again at t+1.
  - issue handshake at t -> the next hart is offered at t+1.
  - Minimum per-hart turnaround is therefore issue(t), retire(t+k), reissue(t+k+1).
- Handshake:
  - While `issue_valid=1` and `issue_ready=0`, `issue_hart` and `issue_pc` stay stable unless a higher-priority hart becomes READY.
  - `rr_ptr` advances only on a handshake, so a stall never reorders the priority rotation.
- Reset mid-operation: asynchronous assertion clears all state immediately. In-flight instructions are forgotten; any later retire for them sets `err`.
- `active`, `all_halted`, `err` and `retire_count` are registered, or derived only from registered state.

## Test plan
- Reset, then idle:
  - Expect `issue_valid=0`, `all_halted=1`, `active=0`.
  - Start hart 2 at `0x103` -> at the next cycle `issue_valid=1`, `issue_hart=2`, `issue_pc=0x100`, `active=4'b0100`.
- Round-robin, `NHARTS=4`:
  - Start harts 0, 1, 3 at `0x0`, `0x40`, `0x80`; hold `issue_ready=1`.
  - Retire each hart one cycle after its issue with `next_pc = pc+4`.
  - Issue order must be 0, 1, 3, 0, 1, 3; after six retires `retire_count=6`.
- Stall:
  - With harts 1 and 3 READY and `issue_ready=0` for 5 cycles, `issue_hart=1` and `issue_pc` hold constant.
  - On release, 1 issues, then 3.
- Wrap-around:
  - With `rr_ptr=3`, harts 3 and 0 READY: the scan wraps, so 3 issues, then 0.
  - After that handshake `rr_ptr=1`.
- Halt:
  - Retire hart 0 with `retire_halt=1` while it is the only active hart.
  - Next cycle: `all_halted=1`, `issue_valid=0`, `pc[0]=retire_next_pc`.
- Errors:
  - Start hart 1 while it is INFLIGHT, and separately retire hart 2 while it is IDLE.
  - Each sets `err=1`, hart state is unchanged, and `retire_count` does not increment for the bad retire.
  - Assert `resetn=0` asynchronously mid-run; all outputs return to their reset values before the next `clk` edge.
